// File: rtl/alu_pkg.sv
// Shared types for the alu_exec execute stage: datapath width, op codes, FSM states.
package alu_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath; one partial-product step per enabled cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product_next,
  output logic               last
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] product;
  logic [CW-1:0]      count;

  // Multiplicand shifts left while the multiplier shifts right, so bit 0 always selects.
  always_comb begin
    product_next = product + (mplier[0] ? mcand : '0);
    last         = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
    end else if (load) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      count   <= '0;
    end else if (step) begin
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      product <= product_next;
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute stage feeding the accumulator: 2-cycle logic/arith ops, 17-cycle MUL.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             load_acc,
  output logic             busy,
  output logic             zero,
  output logic             carry
);

  state_e             state, next_state;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               accept;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               mul_last;

  assign accept   = (state == S_IDLE) && start;
  assign busy     = (state != S_IDLE);
  assign load_acc = (state == S_DONE);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .step         (state == S_MUL),
    .a            (a),
    .b            (b),
    .product_next (mul_next),
    .last         (mul_last)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = (op_e'(op) == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: next_state = S_DONE;
      S_MUL:  if (mul_last) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    case (op_q)
      OP_ADD: begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        sum     = {1'b0, a_q} - {1'b0, b_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = a_q << 1;
        alu_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = a_q >> 1;
        alu_c   = a_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q <= op_e'(op);
        a_q  <= a;
        b_q  <= b;
      end
      if (state == S_EXEC) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
        carry  <= alu_c;
      end else if (state == S_MUL && mul_last) begin
        result <= mul_next[WIDTH-1:0];
        zero   <= (mul_next[WIDTH-1:0] == '0);
        carry  <= |mul_next[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expected values.
module tb_alu_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic [15:0] result;
  logic        load_acc, busy, zero, carry;

  int checks = 0;
  int failures = 0;

  alu_exec #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .load_acc (load_acc),
    .busy     (busy),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_load"}, 32'(load_acc), 32'd0);
  endtask

  // Two-cycle op: accept, EXEC, DONE (strobe + result), back to IDLE.
  task automatic run_single(input string tag, input op_e o, input logic [15:0] va,
                            input logic [15:0] vb, input logic [15:0] er,
                            input logic ez, input logic ec);
    op = o; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; op = 3'(OP_MUL);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_load"}, 32'(load_acc), 32'd0);
    tick();
    check({tag, "_done_load"}, 32'(load_acc), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    tick();
    check_idle_outputs({tag, "_after"});
    check({tag, "_held"}, 32'(result), 32'(er));
  endtask

  // MUL: strobe must appear exactly at accept+17; optional start pulse mid-run.
  task automatic run_mul(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] er, input logic ez, input logic ec,
                         input bit poke);
    op = 3'(OP_MUL); a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0; a = 16'h5555; b = 16'hAAAA; op = 3'(OP_ADD);
    for (int i = 1; i <= 17; i++) begin
      check($sformatf("%s_load_c%0d", tag, i), 32'(load_acc), 32'(i == 17));
      if (i == 17) begin
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        check({tag, "_carry"}, 32'(carry), 32'(ec));
      end
      start = poke && (i == 5 || i == 17);
      tick();
    end
    start = 1'b0;
    check_idle_outputs({tag, "_after"});
    check({tag, "_held"}, 32'(result), 32'(er));
    tick();
    check({tag, "_no_second_load"}, 32'(load_acc), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    tick();
    tick();
    check("rst_result", 32'(result), 32'd0);
    check("rst_load", 32'(load_acc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    rst_n = 1'b1;
    tick();

    run_single("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    run_single("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1);
    run_single("shr_one", OP_SHR, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1);
    run_single("and", OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
    run_single("or", OP_OR, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0);
    run_single("xor_self", OP_XOR, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0);
    run_single("shl_msb", OP_SHL, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b1);

    run_mul("mul_small", 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0, 1'b0);
    run_mul("mul_ovf", 16'h1000, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_mul("mul_poke", 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b1);

    // start held high through EXEC and DONE with different operands: ignored.
    op = 3'(OP_ADD); a = 16'h0001; b = 16'h0002; start = 1'b1;
    tick();
    op = 3'(OP_OR); a = 16'h0100; b = 16'h0100;
    tick();
    check("ign_load", 32'(load_acc), 32'd1);
    check("ign_result", 32'(result), 32'h0003);
    tick();
    start = 1'b0;
    check_idle_outputs("ign_after");
    tick();
    check("ign_no_second_load", 32'(load_acc), 32'd0);
    check("ign_result_held", 32'(result), 32'h0003);

    // Reset while the multiplier is at count 8.
    op = 3'(OP_MUL); a = 16'h00FF; b = 16'h00FF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_result", 32'(result), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_load", 32'(load_acc), 32'd0);
    check("mrst_zero", 32'(zero), 32'd0);
    check("mrst_carry", 32'(carry), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("mrst_noload_%0d", i), 32'(load_acc), 32'd0);
    end

    run_single("add_after_rst", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
